// File: rtl/deit_operand_feeder_pkg.sv
// Shared definitions for the deit_core operand feeder: array geometry,
// stream FSM state encoding and sts_err bit positions.
package deit_operand_feeder_pkg;

  localparam int unsigned ARRAY_ROW = 16;
  localparam int unsigned ARRAY_COL = 16;
  localparam int unsigned ACT_W     = ARRAY_ROW * 8;
  localparam int unsigned WGT_W     = ARRAY_COL * 8;

  typedef enum logic [1:0] {
    FD_IDLE = 2'd0,
    FD_RUN  = 2'd1,
    FD_PAD  = 2'd2
  } fd_state_e;

  localparam int unsigned ERR_A_OVR = 0;
  localparam int unsigned ERR_W_OVR = 1;
  localparam int unsigned ERR_COLL  = 2;
  localparam int unsigned ERR_W     = 3;

endpackage

// File: rtl/feeder_stream.sv
// One operand stream: tile RAM (one or two banks), request FSM and read pointer.
//  clk, rst_n        clock, async active-low reset
//  wr_en/bank/addr/data  host write port
//  rd_bank           bank to read, latched when a pass starts
//  cfg_rows          valid rows per pass, latched when a pass starts
//  en                core request level
//  vec               row vector, one cycle after the request (0 when not serving)
//  busy_nxt_c        FSM will be non-IDLE after this edge
//  ovr_c             request landed in PAD this cycle
//  coll_c            host write into the bank being streamed this cycle
module feeder_stream
  import deit_operand_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 128,
  parameter int unsigned BANKS = 1,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [AW:0]      cfg_rows,
  input  logic             en,
  output logic [WIDTH-1:0] vec,
  output logic             busy_nxt_c,
  output logic             ovr_c,
  output logic             coll_c
);

  localparam int unsigned RAM_D = BANKS * DEPTH;
  localparam int unsigned RAW   = $clog2(RAM_D);
  localparam logic [AW:0] DEPTH_ROWS = (AW+1)'(DEPTH);

  // With a single bank the truncation drops the bank bit.
  function automatic logic [RAW-1:0] ram_idx(input logic bank, input logic [AW-1:0] row);
    return RAW'({bank, row});
  endfunction

  logic [WIDTH-1:0] mem [RAM_D];

  fd_state_e        state_q, state_d;
  logic [AW:0]      ptr_q, ptr_d;
  logic [AW:0]      rows_q, rows_d;
  logic             bank_q, bank_d;
  logic             rd_c;
  logic             rd_bank_c;
  logic [WIDTH-1:0] vec_d;

  // Host write port; RAM is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ram_idx(wr_bank, wr_addr)] <= wr_data;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FD_IDLE;
    else        state_q <= state_d;
  end

  // Next state, pointer and read control.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rows_d    = rows_q;
    bank_d    = bank_q;
    rd_c      = 1'b0;
    rd_bank_c = bank_q;
    ovr_c     = 1'b0;
    if (!en) begin
      state_d = FD_IDLE;
      ptr_d   = '0;
    end else begin
      case (state_q)
        FD_IDLE: begin
          // Clamp so the pointer can never address past the tile.
          rows_d    = (cfg_rows > DEPTH_ROWS) ? DEPTH_ROWS : cfg_rows;
          bank_d    = rd_bank;
          rd_bank_c = rd_bank;
          if (rows_d == '0) begin
            state_d = FD_PAD;
          end else begin
            rd_c    = 1'b1;
            ptr_d   = (AW+1)'(1);
            state_d = (rows_d == (AW+1)'(1)) ? FD_PAD : FD_RUN;
          end
        end
        FD_RUN: begin
          rd_c  = 1'b1;
          ptr_d = ptr_q + (AW+1)'(1);
          if (ptr_d == rows_q) state_d = FD_PAD;
        end
        FD_PAD: ovr_c = 1'b1;
        default: state_d = FD_IDLE;
      endcase
    end
  end

  // Pointer is 0 in IDLE, so ptr_q addresses the right row in every serving state.
  assign vec_d      = rd_c ? mem[ram_idx(rd_bank_c, ptr_q[AW-1:0])] : '0;
  assign busy_nxt_c = (state_d != FD_IDLE);
  assign coll_c     = wr_en && (state_q != FD_IDLE) && ((BANKS == 1) || (wr_bank == bank_q));

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      rows_q <= '0;
      bank_q <= 1'b0;
      vec    <= '0;
    end else begin
      ptr_q  <= ptr_d;
      rows_q <= rows_d;
      bank_q <= bank_d;
      vec    <= vec_d;
    end
  end

endmodule

// File: rtl/deit_operand_feeder.sv
// Operand feeder for deit_core: activation and weight tiles in on-chip RAM,
// streamed to the core on request, filled by the host between runs.
//  host_act_wr_*  / host_w_wr_*   host tile write ports
//  cfg_a_rows / cfg_w_rows        valid rows per pass
//  ctrl_input_stream_en / ctrl_weight_load_en  core request levels
//  in_act_vec / in_weight_vec     row vectors to the core
//  sts_busy                       either stream active
//  sts_err / err_clr              sticky {collision, w_overrun, a_overrun} and clear
// Build option FEEDER_PINGPONG_EN: two banks per operand, adds host_bank_sel
// (write bank) and host_swap (read-bank swap, deferred until both streams are IDLE).
module deit_operand_feeder
  import deit_operand_feeder_pkg::*;
#(
  parameter int unsigned A_DEPTH = 32,
  parameter int unsigned W_DEPTH = 16,
  parameter int unsigned A_AW    = $clog2(A_DEPTH),
  parameter int unsigned W_AW    = $clog2(W_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_act_wr_en,
  input  logic [A_AW-1:0]   host_act_wr_addr,
  input  logic [ACT_W-1:0]  host_act_wr_data,
  input  logic              host_w_wr_en,
  input  logic [W_AW-1:0]   host_w_wr_addr,
  input  logic [WGT_W-1:0]  host_w_wr_data,
  input  logic [A_AW:0]     cfg_a_rows,
  input  logic [W_AW:0]     cfg_w_rows,
  input  logic              ctrl_input_stream_en,
  input  logic              ctrl_weight_load_en,
  output logic [ACT_W-1:0]  in_act_vec,
  output logic [WGT_W-1:0]  in_weight_vec,
  output logic              sts_busy,
  output logic [ERR_W-1:0]  sts_err,
  input  logic              err_clr
`ifdef FEEDER_PINGPONG_EN
  ,
  input  logic              host_bank_sel,
  input  logic              host_swap
`endif
);

`ifdef FEEDER_PINGPONG_EN
  localparam int unsigned BANKS = 2;
`else
  localparam int unsigned BANKS = 1;
`endif

  logic wr_bank_c, rd_bank_c;
  logic a_busy_nxt_c, w_busy_nxt_c;
  logic a_ovr_c, w_ovr_c, a_coll_c, w_coll_c;
  logic [ERR_W-1:0] err_d;

`ifdef FEEDER_PINGPONG_EN
  logic rd_bank_q, swap_pend_q;

  // Read-bank swap, held pending until both streams are IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank_q   <= 1'b0;
      swap_pend_q <= 1'b0;
    end else if ((host_swap || swap_pend_q) && !sts_busy) begin
      rd_bank_q   <= ~rd_bank_q;
      swap_pend_q <= 1'b0;
    end else if (host_swap) begin
      swap_pend_q <= 1'b1;
    end
  end

  assign wr_bank_c = host_bank_sel;
  assign rd_bank_c = rd_bank_q;
`else
  assign wr_bank_c = 1'b0;
  assign rd_bank_c = 1'b0;
`endif

  feeder_stream #(.DEPTH(A_DEPTH), .WIDTH(ACT_W), .BANKS(BANKS), .AW(A_AW)) u_act (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (host_act_wr_en),
    .wr_bank    (wr_bank_c),
    .wr_addr    (host_act_wr_addr),
    .wr_data    (host_act_wr_data),
    .rd_bank    (rd_bank_c),
    .cfg_rows   (cfg_a_rows),
    .en         (ctrl_input_stream_en),
    .vec        (in_act_vec),
    .busy_nxt_c (a_busy_nxt_c),
    .ovr_c      (a_ovr_c),
    .coll_c     (a_coll_c)
  );

  feeder_stream #(.DEPTH(W_DEPTH), .WIDTH(WGT_W), .BANKS(BANKS), .AW(W_AW)) u_wgt (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (host_w_wr_en),
    .wr_bank    (wr_bank_c),
    .wr_addr    (host_w_wr_addr),
    .wr_data    (host_w_wr_data),
    .rd_bank    (rd_bank_c),
    .cfg_rows   (cfg_w_rows),
    .en         (ctrl_weight_load_en),
    .vec        (in_weight_vec),
    .busy_nxt_c (w_busy_nxt_c),
    .ovr_c      (w_ovr_c),
    .coll_c     (w_coll_c)
  );

  // Sticky errors: clear first, so a same-cycle event keeps its bit set.
  always_comb begin
    err_d = err_clr ? '0 : sts_err;
    if (a_ovr_c)              err_d[ERR_A_OVR] = 1'b1;
    if (w_ovr_c)              err_d[ERR_W_OVR] = 1'b1;
    if (a_coll_c || w_coll_c) err_d[ERR_COLL]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_busy <= 1'b0;
      sts_err  <= '0;
    end else begin
      sts_busy <= a_busy_nxt_c || w_busy_nxt_c;
      sts_err  <= err_d;
    end
  end

endmodule
